reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 90 +++++++++
 1 files changed

// File: rtl/reg_file.sv
// Register file with two operand read ports, one debug/trace read port and a
// single writeback port. Register 0 is hard-wired to zero. Each read port
// forwards the in-flight writeback data when it addresses the register being
// written, so a value produced this cycle is visible to its consumers at once.
// A free-running 32-bit counter tracks committed writes.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [31:0]       wr_cnt_q;
  logic [31:0]       wr_cnt_d;
  logic              wr_commit;
  logic              bypass_en;

  // A write to index 0 is discarded; reset priority is applied in the flop block.
  assign wr_commit = we && (waddr != '0);

  // Forwarding is suppressed during reset so reads show the stored values.
  assign bypass_en = rst_n && wr_commit;

  // One read port: forwarded write data, else zero for r0, else stored entry.
  // Every input is an argument so continuous assigns see all dependencies.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              fwd_en,
    input logic [ADDR_W-1:0] fwd_addr,
    input logic [DATA_W-1:0] fwd_data,
    input logic [DATA_W-1:0] stored
  );
    if (fwd_en && (fwd_addr == addr)) begin
      return fwd_data;
    end else if (addr == '0) begin
      return '0;
    end else begin
      return stored;
    end
  endfunction

  assign rdata1   = read_port(raddr1,   bypass_en, waddr, wdata, regs_q[raddr1]);
  assign rdata2   = read_port(raddr2,   bypass_en, waddr, wdata, regs_q[raddr2]);
  assign dbg_data = read_port(dbg_addr, bypass_en, waddr, wdata, regs_q[dbg_addr]);
  assign wr_cnt   = wr_cnt_q;

  // Next value of the write counter; wraps naturally at 32 bits.
  always_comb begin
    // NOTE: give every combinational output a default first so no path can
    // leave it unassigned and infer a latch.
    wr_cnt_d = wr_cnt_q;
    if (wr_commit) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  // Storage and counter update; synchronous reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this array is reset on purpose -- every entry must read zero
      // right after reset, so it is built from resettable flops, not a RAM.
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from values sampled at the same edge.
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      if (wr_commit) begin
        regs_q[waddr] <= wdata;
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

endmodule
